// File: rtl/mic1_exec_ctrl_if.sv
// Front-panel / MIC-1 side signals of the execution controller.
// The panel (or a bench) uses master; the controller uses slave.
interface mic1_exec_ctrl_if #(
  parameter int CNT_WIDTH = 4
) ();
  logic                 btn_run;
  logic                 btn_step;
  logic                 btn_stop;
  logic                 btn_clear;
  logic                 mic1_halt;
  logic                 mic1_ce;
  logic                 led_run;
  logic                 led_idle;
  logic                 led_halt;
  logic [CNT_WIDTH-1:0] step_count;

  modport master (
    output btn_run,
    output btn_step,
    output btn_stop,
    output btn_clear,
    output mic1_halt,
    input  mic1_ce,
    input  led_run,
    input  led_idle,
    input  led_halt,
    input  step_count
  );

  modport slave (
    input  btn_run,
    input  btn_step,
    input  btn_stop,
    input  btn_clear,
    input  mic1_halt,
    output mic1_ce,
    output led_run,
    output led_idle,
    output led_halt,
    output step_count
  );
endinterface

// File: rtl/mic1_exec_ctrl.sv
// MIC-1 execution controller: button edges -> Run/Step/Stop/Halt FSM that
// issues the one-cycle datapath clock-enable and counts issued microinstructions.
module mic1_exec_ctrl #(
  parameter int RATE_DIV  = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  mic1_exec_ctrl_if.slave  bus
);

  localparam int DIV_W = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);

  localparam int B_RUN   = 0;
  localparam int B_STEP  = 1;
  localparam int B_STOP  = 2;
  localparam int B_CLEAR = 3;
  localparam int N_BTN   = 4;

  generate
    if (RATE_DIV < 2) begin : g_bad_rate
      $error("mic1_exec_ctrl: RATE_DIV must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [DIV_W-1:0]     div_reg, div_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next;

  logic [N_BTN-1:0] btn_lvl;
  logic [N_BTN-1:0] cmd;
  logic             ce;

  assign btn_lvl[B_RUN]   = bus.btn_run;
  assign btn_lvl[B_STEP]  = bus.btn_step;
  assign btn_lvl[B_STOP]  = bus.btn_stop;
  assign btn_lvl[B_CLEAR] = bus.btn_clear;

  // History loads 1 in reset so a button held through reset never fires.
  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_edge
      logic hist_reg;

      always_ff @(posedge clk) begin
        if (!resetn) begin
          hist_reg <= 1'b1;
        end else begin
          hist_reg <= btn_lvl[gi];
        end
      end

      assign cmd[gi] = btn_lvl[gi] & ~hist_reg;
    end
  endgenerate

  assign ce = (state_reg == S_STEP) ||
              ((state_reg == S_RUN) && (div_reg == DIV_LAST));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
      div_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    count_next = count_reg;

    if (ce) begin
      count_next = count_reg + 1'b1;
    end

    if (cmd[B_CLEAR]) begin
      // Clear beats everything, including the increment of a live pulse.
      state_next = S_IDLE;
      div_next   = '0;
      count_next = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (!cmd[B_STOP]) begin
            if (cmd[B_RUN]) begin
              state_next = S_RUN;
              div_next   = '0;
            end else if (cmd[B_STEP] && !bus.mic1_halt) begin
              state_next = S_STEP;
            end
          end
        end
        S_RUN: begin
          if (cmd[B_STOP]) begin
            state_next = S_IDLE;
            div_next   = '0;
          end else if (bus.mic1_halt) begin
            state_next = S_HALTED;
            div_next   = '0;
          end else if (div_reg == DIV_LAST) begin
            div_next = '0;
          end else begin
            div_next = div_reg + 1'b1;
          end
        end
        S_STEP: begin
          state_next = S_IDLE;
        end
        S_HALTED: begin
          if (cmd[B_STOP]) begin
            state_next = S_IDLE;
          end
        end
        default: begin
          state_next = S_IDLE;
          div_next   = '0;
        end
      endcase
    end
  end

  assign bus.mic1_ce    = ce;
  assign bus.led_run    = (state_reg == S_RUN);
  assign bus.led_idle   = (state_reg == S_IDLE);
  assign bus.led_halt   = (state_reg == S_HALTED);
  assign bus.step_count = count_reg;

endmodule

// File: tb/tb_mic1_exec_ctrl.sv
// Bench for mic1_exec_ctrl: a cycle-level behavioural model checked every cycle,
// plus directed front-panel scenarios with literal expectations.
module tb_mic1_exec_ctrl;

  localparam int RATE_DIV  = 4;
  localparam int CNT_WIDTH = 4;
  localparam int CNT_MOD   = 1 << CNT_WIDTH;

  localparam int MD_IDLE   = 0;
  localparam int MD_RUN    = 1;
  localparam int MD_STEP   = 2;
  localparam int MD_HALTED = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic btn_run = 1'b0, btn_step = 1'b0, btn_stop = 1'b0, btn_clear = 1'b0;
  logic mic1_halt = 1'b0;

  int errors = 0;
  int checks = 0;
  int ce_seen = 0;

  always #5 clk = ~clk;

  mic1_exec_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  assign bus.btn_run   = btn_run;
  assign bus.btn_step  = btn_step;
  assign bus.btn_stop  = btn_stop;
  assign bus.btn_clear = btn_clear;
  assign bus.mic1_halt = mic1_halt;

  mic1_exec_ctrl #(.RATE_DIV(RATE_DIV), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode, how many cycles the current RUN has lasted, pulse count.
  int m_mode = MD_IDLE;
  int m_age = 0;
  int m_count = 0;
  bit p_run = 1, p_step = 1, p_stop = 1, p_clear = 1;
  bit c_run, c_step, c_stop, c_clear, ce_now;
  bit model_valid = 0;

  function automatic bit model_ce();
    return (m_mode == MD_STEP) || (m_mode == MD_RUN && (m_age % RATE_DIV) == 0);
  endfunction

  always @(posedge clk) begin
    ce_now = model_ce();
    if (!resetn) begin
      m_mode = MD_IDLE; m_age = 0; m_count = 0;
      p_run = 1; p_step = 1; p_stop = 1; p_clear = 1;
    end else begin
      c_run = btn_run && !p_run;       c_step = btn_step && !p_step;
      c_stop = btn_stop && !p_stop;    c_clear = btn_clear && !p_clear;
      p_run = btn_run; p_step = btn_step; p_stop = btn_stop; p_clear = btn_clear;
      if (c_clear) begin
        m_mode = MD_IDLE;
        m_count = 0;
      end else begin
        if (ce_now) m_count = (m_count + 1) % CNT_MOD;
        case (m_mode)
          MD_IDLE: begin
            if (c_stop) m_mode = MD_IDLE;
            else if (c_run) begin m_mode = MD_RUN; m_age = 1; end
            else if (c_step && !mic1_halt) m_mode = MD_STEP;
          end
          MD_RUN: begin
            if (c_stop) m_mode = MD_IDLE;
            else if (mic1_halt) m_mode = MD_HALTED;
            else m_age++;
          end
          MD_STEP: m_mode = MD_IDLE;
          default: if (c_stop) m_mode = MD_IDLE;
        endcase
      end
    end
    model_valid = 1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      cmp("mic1_ce", bus.mic1_ce, model_ce());
      cmp("led_run", bus.led_run, m_mode == MD_RUN);
      cmp("led_idle", bus.led_idle, m_mode == MD_IDLE);
      cmp("led_halt", bus.led_halt, m_mode == MD_HALTED);
      cmp("step_count", bus.step_count, m_count);
      if (bus.mic1_ce === 1'b1) ce_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_once();
    btn_step = 1; tick(1);
    btn_step = 0; tick(1);
  endtask

  initial begin
    // Run held through reset and afterwards: no command.
    btn_run = 1;
    tick(3);
    resetn = 1;
    cmp("reset_count", bus.step_count, 0);
    tick(10);
    cmp("held_run_idle", bus.led_idle, 1);
    cmp("held_run_no_ce", ce_seen, 0);
    btn_run = 0;
    tick(2);
    $display("txn reset_hold_run: idle=%0d ce_seen=%0d", bus.led_idle, ce_seen);

    // Run: pulses in cycles 4, 8, 12 after entry; stop at the end of the third.
    ce_seen = 0;
    btn_run = 1; tick(1);
    btn_run = 0;
    cmp("run_entry_led", bus.led_run, 1);
    tick(11);
    cmp("run_cycle12_ce", bus.mic1_ce, 1);
    btn_stop = 1; tick(1);
    btn_stop = 0;
    cmp("run_stop_idle", bus.led_idle, 1);
    cmp("run_stop_count", bus.step_count, 3);
    cmp("run_pulses", ce_seen, 3);
    tick(1);
    $display("txn run_stop: count=%0d pulses=%0d", bus.step_count, ce_seen);

    // Five separate steps, then one long press.
    for (int i = 0; i < 5; i++) step_once();
    cmp("five_steps", bus.step_count, 8);
    btn_step = 1; tick(20);
    btn_step = 0; tick(2);
    cmp("held_step", bus.step_count, 9);
    $display("txn steps: count=%0d", bus.step_count);

    // Halt during RUN; run/step ignored while halted; stop returns to IDLE.
    btn_run = 1; tick(1);
    btn_run = 0; tick(5);
    mic1_halt = 1; tick(1);
    cmp("halt_led", bus.led_halt, 1);
    btn_run = 1; tick(1);
    btn_run = 0; btn_step = 1; tick(1);
    btn_step = 0; tick(2);
    cmp("halt_sticky", bus.led_halt, 1);
    cmp("halt_count", bus.step_count, 10);
    btn_stop = 1; tick(1);
    btn_stop = 0;
    cmp("halt_stop_idle", bus.led_idle, 1);
    btn_step = 1; tick(1);
    btn_step = 0;
    cmp("idle_step_halted", bus.led_idle, 1);
    mic1_halt = 0; tick(1);
    $display("txn halt: count=%0d", bus.step_count);

    // Clear + run on the edge ending the 8th pulse (count=7).
    btn_clear = 1; tick(1);
    btn_clear = 0;
    cmp("clear_count", bus.step_count, 0);
    tick(1);
    btn_run = 1; tick(1);
    btn_run = 0; tick(31);
    cmp("pre_clear_count", bus.step_count, 7);
    cmp("pre_clear_ce", bus.mic1_ce, 1);
    btn_clear = 1; btn_run = 1; tick(1);
    btn_clear = 0; btn_run = 0;
    cmp("clear_run_idle", bus.led_idle, 1);
    cmp("clear_run_count", bus.step_count, 0);
    tick(1);
    btn_stop = 1; btn_run = 1; tick(1);
    btn_stop = 0; btn_run = 0;
    cmp("stop_run_idle", bus.led_idle, 1);
    tick(1);
    $display("txn clear_priority: count=%0d idle=%0d", bus.step_count, bus.led_idle);

    // Counter wrap after 16 steps.
    for (int i = 1; i <= 16; i++) begin
      step_once();
      if (i == 15) cmp("count_15", bus.step_count, 15);
    end
    cmp("count_wrap", bus.step_count, 0);
    $display("txn wrap: count=%0d", bus.step_count);

    // Reset during STEP and during a RUN pulse.
    step_once();
    btn_step = 1; tick(1);
    cmp("step_ce", bus.mic1_ce, 1);
    btn_step = 0; resetn = 0; tick(1);
    cmp("reset_step_ce", bus.mic1_ce, 0);
    cmp("reset_step_count", bus.step_count, 0);
    resetn = 1; tick(2);
    btn_run = 1; tick(1);
    btn_run = 0; tick(3);
    cmp("run_pulse_ce", bus.mic1_ce, 1);
    resetn = 0; tick(1);
    cmp("reset_run_ce", bus.mic1_ce, 0);
    resetn = 1; tick(2);
    $display("txn reset_mid_op: ce=%0d count=%0d", bus.mic1_ce, bus.step_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
